// File: rtl/count_display_driver_pkg.sv
// Shared constants for the count display driver: segment patterns,
// conversion FSM states and the anode scan table.
package count_display_driver_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_IDLE   = 2'd3
  } conv_state_e;

  // Entry [i] drives digit i low; digit 0 is the rightmost
  localparam logic [3:0][3:0] AN_ONEHOT = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/count_display_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock,
// result committed to bcd only when a conversion completes.
module bin2bcd_seq
  import count_display_driver_pkg::*;
#(
  parameter int IN_WIDTH = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] value,
  output logic [15:0]         bcd,
  output logic                busy
);

  localparam int SR_W  = 16 + IN_WIDTH;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);

  conv_state_e         state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [SR_W-1:0]     adj_s;
  logic [IN_WIDTH-1:0] value_q, value_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [15:0]         bcd_q, bcd_d;
  logic                busy_q, busy_d;

  // Nibbles of 5 or more become >= 8 after +3, so the shift carries into the next digit
  always_comb begin
    adj_s = sr_q;
    for (int i = 0; i < 4; i++) begin
      if (sr_q[IN_WIDTH+4*i +: 4] >= 4'd5) begin
        adj_s[IN_WIDTH+4*i +: 4] = sr_q[IN_WIDTH+4*i +: 4] + 4'd3;
      end else begin
        adj_s[IN_WIDTH+4*i +: 4] = sr_q[IN_WIDTH+4*i +: 4];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    value_d = value_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    case (state_q)
      ST_LOAD: begin
        sr_d    = {16'h0000, value};
        value_d = value;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        sr_d  = adj_s << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(IN_WIDTH - 1)) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_COMMIT: begin
        bcd_d   = sr_q[IN_WIDTH +: 16];
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (value != value_q) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_LOAD;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOAD;
      sr_q    <= '0;
      value_q <= '0;
      cnt_q   <= '0;
      bcd_q   <= 16'h0000;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
    end
  end

  assign bcd  = bcd_q;
  assign busy = busy_q;

endmodule

// File: rtl/count_display_driver.sv
// Converts a binary count to BCD and scans it onto a 4-digit common-anode,
// active-low seven-segment display with leading-zero blanking.
module count_display_driver
  import count_display_driver_pkg::*;
#(
  parameter int IN_WIDTH    = 5,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] value,
  output logic [3:0]          an,
  output logic [6:0]          seg,
  output logic                dp,
  output logic                busy
);

  localparam int PRE_W = $clog2(REFRESH_DIV);

  logic [15:0]      bcd_s;
  logic [3:0]       blank_s;
  logic [3:0]       nib_s;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  bin2bcd_seq #(
    .IN_WIDTH(IN_WIDTH)
  ) u_bin2bcd (
    .clk  (clk),
    .reset(reset),
    .value(value),
    .bcd  (bcd_s),
    .busy (busy)
  );

  // A digit is blank when it and every digit to its left are zero
  always_comb begin
    blank_s[3] = (bcd_s[15:12] == 4'd0);
    blank_s[2] = blank_s[3] && (bcd_s[11:8] == 4'd0);
    blank_s[1] = blank_s[2] && (bcd_s[7:4] == 4'd0);
    blank_s[0] = 1'b0;
  end

  always_comb begin
    if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      pre_d = pre_q + PRE_W'(1);
      idx_d = idx_q;
    end
    nib_s = bcd_s[{idx_q, 2'b00} +: 4];
    an_d  = AN_ONEHOT[idx_q];
    if (blank_s[idx_q]) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = seg_encode(nib_s);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      idx_q <= 2'd0;
      an_q  <= 4'b1110;
      seg_q <= SEG_0;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_count_display_driver.sv
// Self-checking bench for count_display_driver: directed scenarios plus random
// value changes, compared every cycle against a decimal-arithmetic display model.
module tb_count_display_driver;

  localparam int W    = 5;
  localparam int RD   = 4;
  localparam int CONV = W + 2;

  localparam logic [6:0] TB_SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] value = '0;
  logic [3:0]   an;
  logic [6:0]   seg;
  logic         dp;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_pre, m_idx, m_left, m_cap, m_disp;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_busy;

  count_display_driver #(
    .IN_WIDTH   (W),
    .REFRESH_DIV(RD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .value(value),
    .an   (an),
    .seg  (seg),
    .dp   (dp),
    .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] model_seg(input int v, input int i);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (i > 0 && v < p) return 7'b1111111;
    return TB_SEG[(v / p) % 10];
  endfunction

  // Display model: a conversion takes CONV cycles, captures value on its first
  // cycle and publishes the decimal value on its last; outputs lag by one edge
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pre   <= 0;
      m_idx   <= 0;
      m_left  <= CONV;
      m_disp  <= 0;
      exp_an  <= 4'b1110;
      exp_seg <= 7'b1000000;
    end else begin
      exp_an  <= ~(4'b0001 << m_idx);
      exp_seg <= model_seg(m_disp, m_idx);
      if (m_pre == RD - 1) begin
        m_pre <= 0;
        m_idx <= (m_idx + 1) % 4;
      end else begin
        m_pre <= m_pre + 1;
      end
      if (m_left > 0) begin
        if (m_left == CONV) m_cap <= int'(value);
        if (m_left == 1) m_disp <= m_cap;
        m_left <= m_left - 1;
      end else if (int'(value) != m_cap) begin
        m_left <= CONV;
      end
    end
  end

  assign exp_busy = (m_left != 0);

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("an",   {4'b0000, an},   {4'b0000, exp_an});
    chk("seg",  {1'b0, seg},     {1'b0, exp_seg});
    chk("dp",   {7'b0, dp},      8'd1);
    chk("busy", {7'b0, busy},    {7'b0, exp_busy});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_an"},   {4'b0000, an}, 8'b0000_1110);
    chk({tag, "_seg"},  {1'b0, seg},   8'b0100_0000);
    chk({tag, "_dp"},   {7'b0, dp},    8'd1);
    chk({tag, "_busy"}, {7'b0, busy},  8'd1);
  endtask

  // Walk a full scan and check each lit digit against the expected number
  task automatic scan_check(input int v);
    int idx;
    repeat (4 * RD) begin
      step();
      case (an)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      chk("scan_an_onehot", {7'b0, (idx >= 0)}, 8'd1);
      if (idx >= 0) chk("scan_seg", {1'b0, seg}, {1'b0, model_seg(v, idx)});
    end
  endtask

  initial begin
    // 1. Reset power-up and first conversion
    #1 reset = 1'b1;
    value = 5'd0;
    @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;
    for (int i = 1; i <= CONV; i++) begin
      step();
      chk("busy_release", {7'b0, busy}, {7'b0, (i < CONV)});
    end

    // 2. Scan order with value 0
    scan_check(0);

    // 3. Convert 19
    value = 5'd19;
    for (int i = 1; i <= CONV + 1; i++) begin
      step();
      chk("busy_19", {7'b0, busy}, {7'b0, (i <= CONV)});
    end
    scan_check(19);

    // 4. Change during conversion
    value = 5'd7;
    step();
    step();
    value = 5'd12;
    repeat (30) step();
    scan_check(12);

    // 5. Counter wrap 19 -> 0
    value = 5'd19;
    repeat (12) step();
    value = 5'd0;
    repeat (12) step();
    scan_check(0);

    // 6. Async reset mid-SHIFT
    value = 5'd25;
    repeat (3) step();
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_outputs("async_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (12) step();
    scan_check(25);

    // Random value changes, including changes while busy
    repeat (150) begin
      value = W'($urandom_range(0, 31));
      repeat ($urandom_range(1, 12)) step();
    end
    repeat (12) step();
    scan_check(int'(value));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_display_driver.md
Name: count_display_driver

Overview:
- Downstream consumer of the mod-N counter output.
- Takes the binary count and converts it to BCD with a sequential double-dabble engine.
- Time-multiplexes the BCD digits onto a 4-digit, common-anode, active-low seven-segment display.
- Sits between the counter's count bus and the board display pins.

Parameters:
- IN_WIDTH, 5: width of the binary input. Legal range 1..13, so the result fits 4 BCD digits.
- REFRESH_DIV, 100000: clk cycles each digit stays lit. Minimum 2.

Ports:
- clk  input  1  system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- value  input  IN_WIDTH  unsigned binary value to display (the counter's count).
- an  output  4  anode enables, active-low; an[0] is the rightmost digit.
- seg  output  7  segments, active-low, order {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active-low; held 1 (off).
- busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset (asynchronous, immediate):
  - Conversion FSM enters LOAD; bcd_q=16'h0000; digit index=0; prescaler=0.
  - Outputs: an=4'b1110, seg=7'b1000000, dp=1, busy=1.
- Conversion FSM states and transitions:
  - LOAD: shift register <= value, value_q <= value, bit counter <= 0, go to SHIFT.
  - SHIFT: each cycle, first add 3 to every BCD nibble >= 5, then shift the whole register left by 1. After IN_WIDTH shifts, go to COMMIT.
  - COMMIT: bcd_q <= converted nibbles, go to IDLE.
  - IDLE: if value != value_q, go to LOAD; otherwise stay.
- busy:
  - 1 in LOAD, SHIFT and COMMIT; 0 in IDLE.
  - Registered: busy=1 exactly while the state register holds LOAD, SHIFT or COMMIT.
- Latency:
  - A value change seen in IDLE at edge k updates bcd_q at edge k+IN_WIDTH+2.
  - seg/an reflect the new bcd_q one edge later.
- Value changes during conversion:
  - Ignored while busy; the in-flight conversion completes with the old value.
  - IDLE then detects the mismatch and reconverts.
  - No partial results ever reach bcd_q.
- Release from reset: the first conversion starts automatically because the reset state is LOAD.
- Refresh:
  - Prescaler counts 0..REFRESH_DIV-1.
  - At terminal count it wraps to 0 and the digit index increments mod 4 (3 -> 0 wraps).
- Output register (updated every clk):
  - an = one-hot-low of the digit index.
  - seg = encoding of bcd_q nibble[index].
- Leading-zero blanking:
  - Digit i>0 is blanked (seg=7'b1111111) when nibble i and all higher nibbles are 0.
  - Digit 0 is never blanked.
- Encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any nibble >9 shows 1111111 (unreachable).
- Width rules:
  - Shift register is 16+IN_WIDTH bits.
  - Bit counter is wide enough for IN_WIDTH.
  - Prescaler is wide enough for REFRESH_DIV-1.
- Reset mid-conversion: the conversion is abandoned; reset values as above; restarts from LOAD.

Decomposition:
- Shared package/include holds:
  - Seven-segment encoding constants SEG_0..SEG_9 and SEG_BLANK.
  - FSM state localparams ST_LOAD, ST_SHIFT, ST_COMMIT, ST_IDLE.
  - Anode one-hot table.
- Sub-module bin2bcd_seq contains the LOAD/SHIFT/COMMIT/IDLE FSM, value_q compare, busy and bcd_q.
- The top level contains the prescaler, digit scanner, blanking and the output register.

Test Plan:
1. Reset power-up (bench uses REFRESH_DIV=4, IN_WIDTH=5): assert reset, value=0 -> an=1110, seg=1000000, dp=1, busy=1. Release -> busy falls after 7 cycles; bcd_q=0000.
2. Scan order: hold value=0 after reset release -> an steps 1110,1101,1011,0111,1110, each held 4 cycles. Digits 1..3 show 1111111 and digit 0 shows 1000000.
3. Convert 19: set value=19 in IDLE -> busy high 7 cycles; bcd_q=0019 at edge k+7. Digit0 seg=0010000, digit1 seg=1111001, digits 2,3 blanked.
4. Mid-conversion change: value=7, then value=12 while busy -> bcd_q first becomes 0007. A second busy pulse follows; final bcd_q=0012, digit1=1111001, digit0=0100100.
5. Counter wrap: drive value 19 -> 0, with en toggling as the counter does -> display goes from "19" to "0" with digit1 blanked; no glitch values in bcd_q.
6. Async reset mid-SHIFT: pulse reset between clk edges -> an=1110, seg=1000000, busy=1 immediately, without waiting for a clock edge. After release, the value is reconverted correctly.
